qif_spike_monitor: RTL

- Downstream consumer of the QIF neuron's spike output; one instance per neuron.
- Detects spike rising edges, timestamps each edge into an event FIFO, counts spikes per fixed window, and optionally measures the inter-spike interval (ISI).
- Results go to the host/readout logic through a valid/ready event stream plus per-window rate pulses.

---
 rtl/qif_pkg.sv | 11 +
 rtl/qif_event_fifo.sv | 53 +++++
 rtl/qif_spike_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/qif_pkg.sv
// Shared defaults for the QIF neuron, spike monitor and readout blocks.
// Keeping them here keeps timestamp and count widths consistent across blocks.
package qif_pkg;

    localparam int QIF_TS_W   = 16;
    localparam int QIF_DEPTH  = 8;
    localparam int QIF_WINDOW = 256;
    localparam int QIF_CNT_W  = 8;
    localparam int QIF_ISI_W  = 12;

endpackage

// File: rtl/qif_event_fifo.sv
// Synchronous FIFO for spike timestamps.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module qif_event_fifo
    import qif_pkg::*;
#(
    parameter int W     = QIF_TS_W,
    parameter int DEPTH = QIF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_pop;
    logic         w_push;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= din;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qif_spike_monitor.sv
// Spike monitor: edge timestamps into a FIFO, windowed spike rate, and
// inter-spike interval when built with SPIKE_MON_ISI_EN.
module qif_spike_monitor
    import qif_pkg::*;
#(
    parameter int TS_W   = QIF_TS_W,
    parameter int DEPTH  = QIF_DEPTH,
    parameter int WINDOW = QIF_WINDOW,
`ifdef SPIKE_MON_ISI_EN
    parameter int ISI_W  = QIF_ISI_W,
`endif
    parameter int CNT_W  = QIF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    output logic [TS_W-1:0]  evt_ts,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] rate_count,
`ifdef SPIKE_MON_ISI_EN
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
`endif
    output logic             rate_valid
);

    localparam int WC_W = $clog2(WINDOW);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);

    logic             r_spike_d;
    logic [TS_W-1:0]  r_ts;
    logic [WC_W-1:0]  r_win;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_v;
    logic             r_ovf;

    logic             w_edge;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [CNT_W-1:0] w_acc_sum;

    assign w_edge    = en & spike_in & ~r_spike_d;
    assign w_drop    = w_edge & w_full & ~evt_ready;
    assign w_acc_sum = (r_acc == '1) ? r_acc : r_acc + CNT_W'(w_edge);

    qif_event_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_edge),
        .pop   (evt_ready),
        .din   (r_ts),
        .dout  (evt_ts),
        .full  (w_full),
        .empty (w_empty)
    );

    assign evt_valid  = ~w_empty;
    assign ovf        = r_ovf;
    assign rate_count = r_rate;
    assign rate_valid = r_rate_v;

    // The delayed level tracks spike_in even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_d <= 1'b0;
            r_ts      <= '0;
        end else begin
            r_spike_d <= spike_in;
            if (en) begin
                r_ts <= r_ts + TS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // An edge in the closing cycle still belongs to the closing window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win    <= '0;
            r_acc    <= '0;
            r_rate   <= '0;
            r_rate_v <= 1'b0;
        end else begin
            r_rate_v <= 1'b0;
            if (en) begin
                if (r_win == WIN_LAST) begin
                    r_rate   <= w_acc_sum;
                    r_rate_v <= 1'b1;
                    r_acc    <= '0;
                    r_win    <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_win <= r_win + WC_W'(1);
                end
            end
        end
    end

`ifdef SPIKE_MON_ISI_EN
    logic [ISI_W-1:0] r_isi_cnt;
    logic [ISI_W-1:0] r_isi;
    logic             r_isi_first;
    logic             r_isi_v;

    assign isi_out   = r_isi;
    assign isi_valid = r_isi_v;

    // The first edge only arms the interval counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_isi_cnt   <= '0;
            r_isi       <= '0;
            r_isi_first <= 1'b0;
            r_isi_v     <= 1'b0;
        end else begin
            r_isi_v <= 1'b0;
            if (w_edge) begin
                r_isi_cnt <= ISI_W'(1);
                if (r_isi_first) begin
                    r_isi   <= r_isi_cnt;
                    r_isi_v <= 1'b1;
                end else begin
                    r_isi_first <= 1'b1;
                end
            end else if (en && r_isi_cnt != '1) begin
                r_isi_cnt <= r_isi_cnt + ISI_W'(1);
            end
        end
    end
`endif

endmodule
